// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the coefficient-RAM port arbiter.
// Holds the client ids, the arbiter FSM state encoding, the default RAM
// geometry and a small one-hot helper used by the arbiter and its picker.
package ram_port_arbiter_pkg;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 96;   // 8 coefficients x 12 bits

  localparam logic [ID_W-1:0] CLI_CODER = 2'd0;
  localparam logic [ID_W-1:0] CLI_NTT   = 2'd1;
  localparam logic [ID_W-1:0] CLI_AGEN  = 2'd2;
  localparam logic [ID_W-1:0] CLI_CBD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   req        - per-client request vector
//   last_owner - id of the most recent owner; scanning starts one above it
//   winner     - first requester found scanning (last_owner+1) mod N upward
//   any        - at least one request is pending
module rr_picker
  import ram_port_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_owner,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest
  // requester after last_owner is the one left in winner. Offset N wraps to
  // last_owner itself, which therefore has the lowest priority.
  always_comb begin
    winner = last_owner;
    idx    = '0;
    any    = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last_owner + ID_W'(i);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbiter for the single shared coefficient RAM between four datapath
// clients (coder, NTT/add-sub core, A generator, CBD generator).
//
// Handshake: a client raises req and holds it for its whole burst. gnt
// (registered, one-hot) rises the cycle after the client wins. An access is
// accepted in every cycle where both req and gnt are high for that client;
// the cycle in which req drops is not an access. After a release the FSM
// spends one DRAIN cycle with no grant before the next owner is granted.
//
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   req/gnt             - per-client request / one-hot grant
//   wen/ren             - per-client write / read strobes
//   waddr/raddr/wdata   - flattened per-client buses, client i at [i*W +: W]
//   ram_*               - RAM side: write port, read address, read data
//   rdata/rdata_valid   - read data to all clients, one-hot valid
//   owner               - current or last owner id
//   busy                - FSM in GRANT or DRAIN
//   viol                - sticky: a non-granted client strobed wen/ren
//   state               - FSM state, for debug
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  input  logic [N_REQ-1:0]    wen,
  input  logic [N_REQ-1:0]    ren,
  input  logic [N_REQ*AW-1:0] waddr,
  input  logic [N_REQ*AW-1:0] raddr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic                ram_wen,
  output logic [AW-1:0]       ram_waddr,
  output logic [DW-1:0]       ram_wdata,
  output logic [AW-1:0]       ram_raddr,
  input  logic [DW-1:0]       ram_rdata,
  output logic [DW-1:0]       rdata,
  output logic [N_REQ-1:0]    rdata_valid,
  output logic [ID_W-1:0]     owner,
  output logic                busy,
  output logic                viol,
  output state_t              state
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [N_REQ-1:0] rv_q, rv_d;
  logic             viol_q, viol_d;

  logic [ID_W-1:0]  winner;
  logic             any;
  logic             acc;
  logic             rd;

  rr_picker u_picker (
    .req        (req),
    .last_owner (owner_q),
    .winner     (winner),
    .any        (any)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= CLI_CBD;   // so client 0 wins the first tie
      rv_q    <= '0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rv_q    <= rv_d;
      viol_q  <= viol_d;
    end
  end

  // Next-state logic; arbitration runs only in IDLE and DRAIN, so an owner
  // is never preempted.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          owner_d = winner;
        end
      end
      GRANT: begin
        if (!req[owner_q]) state_d = DRAIN;
      end
      DRAIN: begin
        if (any) begin
          state_d = GRANT;
          owner_d = winner;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and next values of the registered outputs
  always_comb begin
    acc       = gnt_q[owner_q] & req[owner_q];
    rd        = acc & ren[owner_q];
    ram_wen   = acc & wen[owner_q];
    ram_waddr = acc ? waddr[owner_q*AW +: AW] : '0;
    ram_wdata = acc ? wdata[owner_q*DW +: DW] : '0;
    ram_raddr = acc ? raddr[owner_q*AW +: AW] : '0;
    gnt_d     = (state_d == GRANT) ? id_onehot(owner_d) : '0;
    // RAM answers one cycle later; tag the returning word with the reader.
    rv_d      = rd ? id_onehot(owner_q) : '0;
    viol_d    = viol_q | (|((wen | ren) & ~gnt_q));
  end

  assign gnt         = gnt_q;
  assign rdata       = ram_rdata;
  assign rdata_valid = rv_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign viol        = viol_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 96;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req, wen, ren;
  logic [N_REQ-1:0]    gnt, rdata_valid;
  logic [N_REQ*AW-1:0] waddr, raddr;
  logic [N_REQ*DW-1:0] wdata;
  logic                ram_wen;
  logic [AW-1:0]       ram_waddr, ram_raddr;
  logic [DW-1:0]       ram_wdata, ram_rdata, rdata;
  logic [ID_W-1:0]     owner;
  logic                busy, viol;
  state_t              state;

  logic [AW-1:0] wa [N_REQ];
  logic [AW-1:0] ra [N_REQ];
  logic [DW-1:0] wd [N_REQ];
  logic [DW-1:0] mem [256];

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] WORD_A = 96'h0000_0000_0000_0000_0000_0ABC;
  localparam logic [DW-1:0] WORD_D = 96'h1234_5678_9ABC_DEF0_1234_5678;
  localparam logic [DW-1:0] WORD_F = 96'h0000_0000_0000_0000_0000_0FFF;

  // clock
  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .wen(wen), .ren(ren),
    .waddr(waddr), .raddr(raddr), .wdata(wdata),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .owner(owner), .busy(busy), .viol(viol),
    .state(state)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      waddr[i*AW +: AW] = wa[i];
      raddr[i*AW +: AW] = ra[i];
      wdata[i*DW +: DW] = wd[i];
    end
  end

  // RAM model: synchronous write, one-cycle read latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= '0;
    ram_rdata <= '0;
  end
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_REQ-1:0] oh(input int id);
    logic [N_REQ-1:0] one;
    one = 4'b0001;
    return one << id;
  endfunction

  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0; req = '0; wen = '0; ren = '0;
    for (int i = 0; i < N_REQ; i++) begin
      wa[i] = '0; ra[i] = '0; wd[i] = '0;
    end

    // ---- reset values
    tick(); tick(); #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rv", rdata_valid, 4'b0000);
    chk("rst_owner", owner, 2'd3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_viol", viol, 1'b0);
    chk("rst_ram_wen", ram_wen, 1'b0);
    chk("rst_state", state, IDLE);
    rst = 1'b1;

    // ---- client 0 writes 0x10 for three cycles
    tick(); req = 4'b0001; wa[0] = 8'h10; wd[0] = WORD_A; #1;
    chk("t1_gnt_pre", gnt, 4'b0000);
    chk("t1_waddr_idle", ram_waddr, 8'h00);
    chk("t1_wen_idle", ram_wen, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(); wen = 4'b0001; #1;
      chk("t1_gnt", gnt, 4'b0001);
      chk("t1_owner", owner, 2'd0);
      chk("t1_ram_wen", ram_wen, 1'b1);
      chk("t1_ram_waddr", ram_waddr, 8'h10);
      chk("t1_ram_wdata", ram_wdata, WORD_A);
    end
    tick(); req = 4'b0000; wen = 4'b0000; #1;
    chk("t1_drop_gnt", gnt, 4'b0001);
    chk("t1_drop_wen", ram_wen, 1'b0);
    tick(); #1;
    chk("t1_drain_gnt", gnt, 4'b0000);
    chk("t1_drain_state", state, DRAIN);
    chk("t1_drain_busy", busy, 1'b1);
    tick(); #1;
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_state", state, IDLE);
    chk("t1_mem10", mem[8'h10], WORD_A);
    chk("t1_viol", viol, 1'b0);

    // ---- all four request after reset: grants 0,1,2,3,0
    tick(); rst = 1'b0; #1;
    tick(); rst = 1'b1; #1;
    chk("t2_owner_rst", owner, 2'd3);
    tick(); req = 4'b1111; #1;
    chk("t2_gnt_pre", gnt, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick(); req = 4'b1111; #1;
      chk("t2_gnt", gnt, oh(exp_seq[k]));
      chk("t2_owner", owner, exp_seq[k][1:0]);
      tick(); req[exp_seq[k]] = 1'b0; #1;
      chk("t2_gnt_hold", gnt, oh(exp_seq[k]));
      tick(); req = 4'b1111; #1;
      chk("t2_gap_gnt", gnt, 4'b0000);
      chk("t2_gap_state", state, DRAIN);
    end
    tick(); req = 4'b0000; #1;
    chk("t2_last_gnt", gnt, 4'b0010);
    tick(); tick(); #1;
    chk("t2_idle_busy", busy, 1'b0);

    // ---- client 1 writes then reads 0x20 in its last cycle
    tick(); req = 4'b0010; #1;
    tick(); wen = 4'b0010; wa[1] = 8'h20; wd[1] = WORD_D; #1;
    chk("t3_gnt", gnt, 4'b0010);
    chk("t3_ram_waddr", ram_waddr, 8'h20);
    tick(); wen = 4'b0000; ren = 4'b0010; ra[1] = 8'h20; #1;
    chk("t3_ram_raddr", ram_raddr, 8'h20);
    chk("t3_rv_pre", rdata_valid, 4'b0000);
    tick(); req = 4'b0000; ren = 4'b0000; #1;
    chk("t3_rv", rdata_valid, 4'b0010);
    chk("t3_rdata", rdata, WORD_D);
    chk("t3_raddr_masked", ram_raddr, 8'h00);
    tick(); #1;
    chk("t3_rv_drain", rdata_valid, 4'b0000);
    chk("t3_drain_state", state, DRAIN);
    tick(); #1;

    // ---- client 2 writes while client 3 owns
    tick(); req = 4'b1000; #1;
    tick(); wen = 4'b0100; wa[2] = 8'h05; wd[2] = WORD_F; #1;
    chk("t4_gnt", gnt, 4'b1000);
    chk("t4_ram_wen", ram_wen, 1'b0);
    chk("t4_ram_waddr", ram_waddr, 8'h00);
    chk("t4_viol_pre", viol, 1'b0);
    tick(); wen = 4'b0000; #1;
    chk("t4_viol_set", viol, 1'b1);
    tick(); req = 4'b0000; #1;
    tick(); tick(); #1;
    chk("t4_viol_sticky", viol, 1'b1);
    chk("t4_idle_state", state, IDLE);
    chk("t4_mem05", mem[8'h05], 96'h0);

    // ---- reset during a client 1 read
    tick(); req = 4'b0010; #1;
    tick(); ren = 4'b0010; ra[1] = 8'h20; rst = 1'b0; #1;
    chk("t5_gnt", gnt, 4'b0010);
    chk("t5_raddr", ram_raddr, 8'h20);
    tick(); rst = 1'b1; ren = 4'b0000; req = 4'b0000; #1;
    chk("t5_gnt_rst", gnt, 4'b0000);
    chk("t5_rv_rst", rdata_valid, 4'b0000);
    chk("t5_owner_rst", owner, 2'd3);
    chk("t5_busy_rst", busy, 1'b0);
    chk("t5_viol_rst", viol, 1'b0);
    tick(); req = 4'b0001; #1;
    tick(); #1;
    chk("t5_gnt0", gnt, 4'b0001);
    chk("t5_owner0", owner, 2'd0);

    // ---- owner 3 releases, 3 and 0 request in DRAIN: 0 wins
    tick(); req = 4'b1000; #1;
    tick(); #1;
    chk("t6_drain1", state, DRAIN);
    tick(); #1;
    chk("t6_gnt3", gnt, 4'b1000);
    chk("t6_owner3", owner, 2'd3);
    tick(); req = 4'b0000; #1;
    chk("t6_gnt3_hold", gnt, 4'b1000);
    tick(); req = 4'b1001; #1;
    chk("t6_drain2_gnt", gnt, 4'b0000);
    chk("t6_drain2_state", state, DRAIN);
    tick(); #1;
    chk("t6_gnt0", gnt, 4'b0001);
    chk("t6_owner0", owner, 2'd0);
    tick(); req = 4'b0000; #1;
    tick(); tick(); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
